// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: byte width and default FIFO depth for the RX and TX buffers.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_DATA_W    = 8;
  localparam int unsigned RX_FIFO_DEPTH  = 16;
  localparam int unsigned RX_FIFO_ADDR_W = $clog2(RX_FIFO_DEPTH);

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side read port of the UART RX FIFO: pop/clear requests in, head byte and status out.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DataW = UART_DATA_W,
  parameter int unsigned AddrW = RX_FIFO_ADDR_W
);

  logic             rd_en;
  logic             clr_overflow;
  logic [DataW-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [AddrW:0]   count;
  logic             overflow;

  modport master (
    output rd_en, clr_overflow,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  rd_en, clr_overflow,
    output rd_data, empty, full, count, overflow
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic single-clock show-ahead FIFO with registered count/empty/full flags.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rd_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AddrW:0]   count_o
);

  typedef logic [AddrW-1:0] ptr_t;
  typedef logic [AddrW:0]   cnt_t;

  logic [Width-1:0] mem_q [Depth];
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic empty_q, empty_d, full_q, full_d;
  logic pop, push;

  // A simultaneous pop frees the slot, so a write into a full FIFO is still accepted.
  assign pop  = rd_i & ~empty_q;
  assign push = wr_i & (~full_q | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    if (push && !pop)      count_d = count_q + cnt_t'(1);
    else if (pop && !push) count_d = count_q - cnt_t'(1);
    empty_d = (count_d == cnt_t'(0));
    full_d  = (count_d == cnt_t'(Depth));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures a byte on each falling edge of data_strobe into a show-ahead FIFO
// and tracks a sticky overflow flag for bytes dropped while full.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = RX_FIFO_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              data_strobe,
  uart_rx_fifo_if.slave     rd_if
);

  logic strobe_q;
  logic overflow_q, overflow_d;
  logic wr_req, pop, drop;

  assign wr_req = strobe_q & ~data_strobe;
  assign pop    = rd_if.rd_en & ~rd_if.empty;
  assign drop   = wr_req & rd_if.full & ~pop;

  // Set has priority over clear so a drop in the clearing cycle is never lost.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)                    overflow_d = 1'b1;
    else if (rd_if.clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      strobe_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q   <= data_strobe;
      overflow_q <= overflow_d;
    end
  end

  assign rd_if.overflow = overflow_q;

  sync_fifo #(
    .Width (DATA_W),
    .Depth (DEPTH),
    .AddrW (ADDR_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .wr_i    (wr_req),
    .wdata_i (rx_data),
    .rd_i    (rd_if.rd_en),
    .rdata_o (rd_if.rd_data),
    .empty_o (rd_if.empty),
    .full_o  (rd_if.full),
    .count_o (rd_if.count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus hand sequences for wrap, overflow and reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       data_strobe;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo_if #(.DataW(8), .AddrW(4)) rd_if ();

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .data_strobe (data_strobe),
    .rd_if       (rd_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rx;
    logic       strb;
    logic       rd;
    logic       clr;
    logic       e_empty;
    logic [4:0] e_count;
    logic       e_ovf;
    logic       chk_data;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(logic [7:0] rx, logic strb, logic rd, logic clr, logic e_empty,
                              logic [4:0] e_count, logic e_ovf, logic chk_data,
                              logic [7:0] e_data);
    vec_t v;
    v.rx = rx; v.strb = strb; v.rd = rd; v.clr = clr; v.e_empty = e_empty;
    v.e_count = e_count; v.e_ovf = e_ovf; v.chk_data = chk_data; v.e_data = e_data;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Holds data_strobe high for hi cycles, then drops it with byte b; rd/clr only in the fall cycle.
  task automatic frame(input logic [7:0] b, input int hi, input logic rd, input logic clr);
    data_strobe = 1'b1;
    repeat (hi) step();
    data_strobe        = 1'b0;
    rx_data            = b;
    rd_if.rd_en        = rd;
    rd_if.clr_overflow = clr;
    step();
    rd_if.rd_en        = 1'b0;
    rd_if.clr_overflow = 1'b0;
  endtask

  task automatic pop_one();
    rd_if.rd_en = 1'b1;
    step();
    rd_if.rd_en = 1'b0;
  endtask

  initial begin
    reset              = 1'b0;
    rx_data            = 8'h00;
    data_strobe        = 1'b0;
    rd_if.rd_en        = 1'b0;
    rd_if.clr_overflow = 1'b0;

    // rx, strb, rd, clr | empty, count, ovf, chk_data, data
    vecs[0]  = mk(8'h00, 1, 0, 0, 1, 0, 0, 0, 8'h00);
    vecs[1]  = mk(8'hA5, 0, 0, 0, 0, 1, 0, 1, 8'hA5);
    vecs[2]  = mk(8'hA5, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    vecs[3]  = mk(8'hA5, 1, 0, 0, 1, 0, 0, 0, 8'h00);
    vecs[4]  = mk(8'h3C, 0, 1, 0, 0, 1, 0, 1, 8'h3C);
    vecs[5]  = mk(8'h3C, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    vecs[6]  = mk(8'h3C, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    vecs[7]  = mk(8'h3C, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    vecs[8]  = mk(8'h3C, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    vecs[9]  = mk(8'h3C, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    vecs[10] = mk(8'h3C, 0, 1, 0, 1, 0, 0, 0, 8'h00);
    vecs[11] = mk(8'h11, 1, 0, 0, 1, 0, 0, 0, 8'h00);
    vecs[12] = mk(8'h11, 0, 0, 0, 0, 1, 0, 1, 8'h11);
    vecs[13] = mk(8'h22, 1, 0, 0, 0, 1, 0, 1, 8'h11);
    vecs[14] = mk(8'h22, 0, 0, 0, 0, 2, 0, 1, 8'h11);
    vecs[15] = mk(8'h22, 0, 1, 0, 0, 1, 0, 1, 8'h22);
    vecs[16] = mk(8'h33, 1, 1, 0, 1, 0, 0, 0, 8'h00);
    vecs[17] = mk(8'h33, 0, 1, 0, 0, 1, 0, 1, 8'h33);
    vecs[18] = mk(8'h33, 0, 1, 0, 1, 0, 0, 0, 8'h00);

    // Reset state and single long frame
    do_reset();
    check("reset_empty", rd_if.empty, 1);
    check("reset_full", rd_if.full, 0);
    check("reset_count", rd_if.count, 0);
    check("reset_ovf", rd_if.overflow, 0);
    frame(8'hA5, 65, 1'b0, 1'b0);
    check("single_empty", rd_if.empty, 0);
    check("single_count", rd_if.count, 1);
    check("single_data", rd_if.rd_data, 8'hA5);
    pop_one();
    check("single_pop_empty", rd_if.empty, 1);
    check("single_pop_count", rd_if.count, 0);

    // Vector table
    for (int i = 0; i < 19; i++) begin
      rx_data     = vecs[i].rx;
      data_strobe = vecs[i].strb;
      rd_if.rd_en = vecs[i].rd;
      rd_if.clr_overflow = vecs[i].clr;
      step();
      check($sformatf("vec%0d_empty", i), rd_if.empty, vecs[i].e_empty);
      check($sformatf("vec%0d_count", i), rd_if.count, vecs[i].e_count);
      check($sformatf("vec%0d_ovf", i), rd_if.overflow, vecs[i].e_ovf);
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), rd_if.rd_data, vecs[i].e_data);
    end
    rd_if.rd_en = 1'b0;

    // Burst to full, overflow, clear-vs-set priority, ordered drain
    do_reset();
    for (int i = 0; i < 16; i++) frame(8'(i), 3, 1'b0, 1'b0);
    check("burst_full", rd_if.full, 1);
    check("burst_count", rd_if.count, 16);
    check("burst_ovf", rd_if.overflow, 0);
    frame(8'hFF, 3, 1'b0, 1'b0);
    check("drop_ovf", rd_if.overflow, 1);
    check("drop_count", rd_if.count, 16);
    frame(8'hEE, 3, 1'b0, 1'b1);
    check("clr_set_ovf", rd_if.overflow, 1);
    rd_if.clr_overflow = 1'b1;
    step();
    rd_if.clr_overflow = 1'b0;
    check("clr_alone_ovf", rd_if.overflow, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_data", i), rd_if.rd_data, i);
      pop_one();
    end
    check("drain_empty", rd_if.empty, 1);

    // Wrapped pointers, write coincident with pop while full
    do_reset();
    for (int i = 0; i < 15; i++) frame(8'h10 + 8'(i), 2, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) pop_one();
    check("wrap_pre_empty", rd_if.empty, 1);
    for (int i = 0; i < 16; i++) frame(8'h20 + 8'(i), 2, 1'b0, 1'b0);
    check("wrap_full", rd_if.full, 1);
    frame(8'h77, 2, 1'b1, 1'b0);
    check("wrap_rw_count", rd_if.count, 16);
    check("wrap_rw_full", rd_if.full, 1);
    check("wrap_rw_ovf", rd_if.overflow, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("wrap%0d_data", i), rd_if.rd_data, (i == 15) ? 8'h77 : 8'h21 + 8'(i));
      pop_one();
    end
    check("wrap_end_empty", rd_if.empty, 1);

    // Reset mid-frame
    do_reset();
    for (int i = 0; i < 3; i++) frame(8'h40 + 8'(i), 2, 1'b0, 1'b0);
    check("mid_pre_count", rd_if.count, 3);
    data_strobe = 1'b1;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_count", rd_if.count, 0);
    check("mid_rst_empty", rd_if.empty, 1);
    repeat (10) step();
    data_strobe = 1'b0;
    rx_data     = 8'h5A;
    step();
    check("mid_cap_count", rd_if.count, 1);
    check("mid_cap_data", rd_if.rd_data, 8'h5A);

    // Fall in the first cycle after reset release is not captured
    data_strobe = 1'b1;
    reset       = 1'b0;
    step();
    reset       = 1'b1;
    data_strobe = 1'b0;
    rx_data     = 8'h99;
    step();
    step();
    check("post_rst_fall_count", rd_if.count, 0);
    check("post_rst_fall_empty", rd_if.empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
